// File: rtl/z80_pkg.sv
// Shared Z80 definitions: register codes, flag bit positions, M-cycle encodings,
// write-back destinations and the 16-bit add sequencer state type.
package z80_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] REG_BC = 2'd0;
    localparam logic [1:0] REG_DE = 2'd1;
    localparam logic [1:0] REG_HL = 2'd2;
    localparam logic [1:0] REG_SP = 2'd3;

    localparam int unsigned FLAG_C_NUM  = 0;
    localparam int unsigned FLAG_N_NUM  = 1;
    localparam int unsigned FLAG_PV_NUM = 2;
    localparam int unsigned FLAG_X_NUM  = 3;
    localparam int unsigned FLAG_H_NUM  = 4;
    localparam int unsigned FLAG_Y_NUM  = 5;
    localparam int unsigned FLAG_Z_NUM  = 6;
    localparam int unsigned FLAG_S_NUM  = 7;

    localparam logic [2:0] CYCLE_NONE     = 3'd0;
    localparam logic [2:0] CYCLE_INTERNAL = 3'd4;

    localparam logic [1:0] DST_HL = 2'd0;
    localparam logic [1:0] DST_IX = 2'd1;
    localparam logic [1:0] DST_IY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } add16_state_e;

    function automatic logic [1:0] dst_code(input logic use_idx, input logic sel_iy);
        if (!use_idx) return DST_HL;
        return sel_iy ? DST_IY : DST_IX;
    endfunction

endpackage

// File: rtl/z80_add8_hc.sv
// 8-bit adder a + b + cin with carry out of bit 3 (half) and bit 7 (carry).
module z80_add8_hc (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_half,
    output logic       o_carry
);
    logic [4:0] w_lo;
    logic [4:0] w_hi;

    always_comb begin
        w_lo    = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + 5'(i_cin);
        w_hi    = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'(w_lo[4]);
        o_sum   = {w_hi[3:0], w_lo[3:0]};
        o_half  = w_lo[4];
        o_carry = w_hi[4];
    end

endmodule

// File: rtl/z80_add16_seq.sv
// Z80 ADD HL/IX/IY,ss sequenced as a 4-clock low-byte and 3-clock high-byte M-cycle.
// Define Z80_UNDOC_XY_FLAGS_EN to copy result bits 13/11 into flag bits 5/3.
module z80_add16_seq
    import z80_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        use_idx,
    input  logic        iy,
    input  logic [1:0]  ss,
    input  logic [15:0] bc_in,
    input  logic [15:0] de_in,
    input  logic [15:0] hl_in,
    input  logic [15:0] ix_in,
    input  logic [15:0] iy_in,
    input  logic [15:0] sp_in,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic        wr_en,
    output logic [1:0]  wr_dst,
    output logic [15:0] result_out,
    output logic [7:0]  f_out,
    output logic [2:0]  mcycle_type,
    output logic [2:0]  tstate
);
    add16_state_e      r_state;
    logic [2:0]        r_tstate;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [7:0]        r_f;
    logic [1:0]        r_dst;
    logic [BYTE_W-1:0] r_lo_sum;
    logic              r_lo_carry;
    logic              r_busy;
    logic              r_done;
    logic              r_wr_en;
    logic [1:0]        r_wr_dst;
    logic [DATA_W-1:0] r_result;
    logic [7:0]        r_f_out;
    logic [2:0]        r_mcycle;

    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic              w_in_hi;
    logic [BYTE_W-1:0] w_a;
    logic [BYTE_W-1:0] w_b;
    logic              w_cin;
    logic [BYTE_W-1:0] w_sum;
    logic              w_half;
    logic              w_carry;
    logic [7:0]        w_f_new;

    // Operand selection on the live inputs; only used on the accepting edge.
    always_comb begin
        w_op1 = use_idx ? (iy ? iy_in : ix_in) : hl_in;
        case (ss)
            REG_BC:  w_op2 = bc_in;
            REG_DE:  w_op2 = de_in;
            REG_HL:  w_op2 = w_op1;
            default: w_op2 = sp_in;
        endcase
    end

    // One byte adder shared by both halves; the high half chains the saved carry.
    always_comb begin
        w_in_hi = (r_state == ST_HI);
        w_a     = w_in_hi ? r_op1[15:8] : r_op1[7:0];
        w_b     = w_in_hi ? r_op2[15:8] : r_op2[7:0];
        w_cin   = w_in_hi ? r_lo_carry : 1'b0;
    end

    z80_add8_hc u_add8 (
        .i_a     (w_a),
        .i_b     (w_b),
        .i_cin   (w_cin),
        .o_sum   (w_sum),
        .o_half  (w_half),
        .o_carry (w_carry)
    );

    // High-byte half carry is the carry out of bit 11 of the 16-bit sum.
    always_comb begin
        w_f_new             = r_f;
        w_f_new[FLAG_H_NUM] = w_half;
        w_f_new[FLAG_N_NUM] = 1'b0;
        w_f_new[FLAG_C_NUM] = w_carry;
`ifdef Z80_UNDOC_XY_FLAGS_EN
        w_f_new[FLAG_Y_NUM] = w_sum[5];
        w_f_new[FLAG_X_NUM] = w_sum[3];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tstate   <= 3'd0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_f        <= '0;
            r_dst      <= DST_HL;
            r_lo_sum   <= '0;
            r_lo_carry <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_dst   <= DST_HL;
            r_result   <= '0;
            r_f_out    <= '0;
            r_mcycle   <= CYCLE_NONE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done  <= 1'b0;
                    r_wr_en <= 1'b0;
                    if (start) begin
                        r_op1    <= w_op1;
                        r_op2    <= w_op2;
                        r_f      <= f_in;
                        r_dst    <= dst_code(use_idx, iy);
                        r_state  <= ST_LO;
                        r_tstate <= 3'd1;
                        r_busy   <= 1'b1;
                        r_mcycle <= CYCLE_INTERNAL;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LO: begin
                    if (r_tstate == 3'd4) begin
                        r_lo_sum   <= w_sum;
                        r_lo_carry <= w_carry;
                        r_state    <= ST_HI;
                        r_tstate   <= 3'd1;
                    end else begin
                        r_tstate <= r_tstate + 3'd1;
                    end
                end
                ST_HI: begin
                    if (r_tstate == 3'd3) begin
                        r_result <= {w_sum, r_lo_sum};
                        r_f_out  <= w_f_new;
                        r_wr_dst <= r_dst;
                        r_done   <= 1'b1;
                        r_wr_en  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_tstate <= 3'd0;
                        r_mcycle <= CYCLE_NONE;
                        r_state  <= ST_DONE;
                    end else begin
                        r_tstate <= r_tstate + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign wr_en       = r_wr_en;
    assign wr_dst      = r_wr_dst;
    assign result_out  = r_result;
    assign f_out       = r_f_out;
    assign mcycle_type = r_mcycle;
    assign tstate      = r_tstate;

endmodule

// File: tb/tb_z80_add16_seq.sv
// Bench for z80_add16_seq: cycle-by-cycle comparison against a timeline model,
// directed literal cases, then randomized traffic with occasional resets.
module tb_z80_add16_seq;
    import z80_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        use_idx;
    logic        iy;
    logic [1:0]  ss;
    logic [15:0] bc_in, de_in, hl_in, ix_in, iy_in, sp_in;
    logic [7:0]  f_in;
    logic        busy, done, wr_en;
    logic [1:0]  wr_dst;
    logic [15:0] result_out;
    logic [7:0]  f_out;
    logic [2:0]  mcycle_type;
    logic [2:0]  tstate;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    z80_add16_seq dut (
        .clk(clk), .reset(reset), .start(start), .use_idx(use_idx), .iy(iy), .ss(ss),
        .bc_in(bc_in), .de_in(de_in), .hl_in(hl_in), .ix_in(ix_in), .iy_in(iy_in),
        .sp_in(sp_in), .f_in(f_in), .busy(busy), .done(done), .wr_en(wr_en),
        .wr_dst(wr_dst), .result_out(result_out), .f_out(f_out),
        .mcycle_type(mcycle_type), .tstate(tstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural model: what ADD rr,ss produces, independent of sequencing.
    function automatic logic [15:0] op1_of(input logic ui, input logic yi,
                                           input logic [15:0] hl, input logic [15:0] ix,
                                           input logic [15:0] iyv);
        return ui ? (yi ? iyv : ix) : hl;
    endfunction

    function automatic logic [15:0] op2_of(input logic [1:0] s, input logic [15:0] o1,
                                           input logic [15:0] bc, input logic [15:0] de,
                                           input logic [15:0] sp);
        case (s)
            2'd0:    return bc;
            2'd1:    return de;
            2'd2:    return o1;
            default: return sp;
        endcase
    endfunction

    function automatic logic [7:0] flags_of(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] fi);
        logic [16:0] s;
        logic [12:0] h;
        logic [7:0]  f;
        s = {1'b0, a} + {1'b0, b};
        h = {1'b0, a[11:0]} + {1'b0, b[11:0]};
        f = fi;
        f[4] = h[12];
        f[1] = 1'b0;
        f[0] = s[16];
`ifdef Z80_UNDOC_XY_FLAGS_EN
        f[5] = s[13];
        f[3] = s[11];
`endif
        return f;
    endfunction

    function automatic logic [1:0] dst_of(input logic ui, input logic yi);
        return ui ? (yi ? DST_IY : DST_IX) : DST_HL;
    endfunction

    // Timeline model: m_phase counts clocks since the accepting edge (0 = idle).
    int          m_phase;
    logic [15:0] m_op1, m_op2, m_res;
    logic [7:0]  m_fl, m_f;
    logic [1:0]  m_dst_l, m_dst;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_res   <= '0;
            m_f     <= '0;
            m_dst   <= DST_HL;
        end else if ((m_phase == 0 || m_phase == 8) && start) begin
            m_phase <= 1;
            m_op1   <= op1_of(use_idx, iy, hl_in, ix_in, iy_in);
            m_op2   <= op2_of(ss, op1_of(use_idx, iy, hl_in, ix_in, iy_in), bc_in, de_in, sp_in);
            m_fl    <= f_in;
            m_dst_l <= dst_of(use_idx, iy);
        end else if (m_phase >= 1 && m_phase <= 7) begin
            m_phase <= m_phase + 1;
            if (m_phase == 7) begin
                m_res <= m_op1 + m_op2;
                m_f   <= flags_of(m_op1, m_op2, m_fl);
                m_dst <= m_dst_l;
            end
        end else begin
            m_phase <= 0;
        end
    end

    logic       e_busy, e_done;
    logic [2:0] e_tstate;
    assign e_busy   = (m_phase >= 1) && (m_phase <= 7);
    assign e_done   = (m_phase == 8);
    assign e_tstate = !e_busy ? 3'd0 : ((m_phase <= 4) ? 3'(m_phase) : 3'(m_phase - 4));

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 16'(busy), 16'(e_busy));
            check("done", 16'(done), 16'(e_done));
            check("wr_en", 16'(wr_en), 16'(e_done));
            check("tstate", 16'(tstate), 16'(e_tstate));
            check("mcycle", 16'(mcycle_type), 16'(e_busy ? CYCLE_INTERNAL : CYCLE_NONE));
            check("result", result_out, m_res);
            check("f_out", 16'(f_out), 16'(m_f));
            check("wr_dst", 16'(wr_dst), 16'(m_dst));
        end
    end

    task automatic scramble();
        bc_in = 16'($urandom); de_in = 16'($urandom); hl_in = 16'($urandom);
        ix_in = 16'($urandom); iy_in = 16'($urandom); sp_in = 16'($urandom);
        f_in  = 8'($urandom);
        use_idx = 1'($urandom); iy = 1'($urandom); ss = 2'($urandom);
    endtask

    // Issue one add; inputs are scrambled right after acceptance and start toggles while busy.
    task automatic run_op(input string nm, input logic ui, input logic yi, input logic [1:0] s,
                          input logic [15:0] o1, input logic [15:0] o2, input logic [7:0] fi,
                          input logic [15:0] er, input logic [7:0] ef, input logic [1:0] ed);
        logic [2:0] ts_tab [0:6];
        int k;
        int busy_cnt;
        ts_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3};
        scramble();
        use_idx = ui; iy = yi; ss = s; f_in = fi;
        if (!ui)     hl_in = o1;
        else if (yi) iy_in = o1;
        else         ix_in = o1;
        bc_in = o2; de_in = o2; sp_in = o2;
        start = 1'b1;
        @(negedge clk);
        scramble();
        start = 1'($urandom);
        k = 1;
        busy_cnt = 0;
        while (!done && k < 20) begin
            if (k <= 7) check({nm, " tseq"}, 16'(tstate), 16'(ts_tab[k-1]));
            if (busy) busy_cnt++;
            @(negedge clk);
            k++;
            start = (k < 8) ? 1'($urandom) : 1'b0;
        end
        start = 1'b0;
        check({nm, " latency"}, 16'(k), 16'd8);
        check({nm, " busy_cnt"}, 16'(busy_cnt), 16'd7);
        check({nm, " result"}, result_out, er);
        check({nm, " f"}, 16'(f_out), 16'(ef));
        check({nm, " dst"}, 16'(wr_dst), 16'(ed));
        @(negedge clk);
        check({nm, " no_extra_done"}, 16'(done), 16'd0);
        check({nm, " hold"}, result_out, er);
    endtask

    initial begin
        int k;
        int seen_done;
        reset = 1'b1;
        start = 1'b0;
        scramble();
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("rst busy", 16'(busy), 16'd0);
        check("rst done", 16'(done), 16'd0);
        check("rst result", result_out, 16'h0000);
        check("rst mcycle", 16'(mcycle_type), 16'(CYCLE_NONE));
        reset = 1'b0;
        @(negedge clk);

`ifdef Z80_UNDOC_XY_FLAGS_EN
        run_op("ix_bc", 1'b1, 1'b0, 2'd0, 16'h0FFF, 16'h0001, 8'hFF, 16'h1000, 8'hD4, DST_IX);
        run_op("iy_self", 1'b1, 1'b1, 2'd2, 16'h8000, 16'h0000, 8'h00, 16'h0000, 8'h01, DST_IY);
        run_op("hl_de", 1'b0, 1'b0, 2'd1, 16'h1234, 16'h1111, 8'h00, 16'h2345, 8'h20, DST_HL);
        run_op("hl_self", 1'b0, 1'b0, 2'd2, 16'hFFFF, 16'h0000, 8'h00, 16'hFFFE, 8'h39, DST_HL);
`else
        run_op("ix_bc", 1'b1, 1'b0, 2'd0, 16'h0FFF, 16'h0001, 8'hFF, 16'h1000, 8'hFC, DST_IX);
        run_op("iy_self", 1'b1, 1'b1, 2'd2, 16'h8000, 16'h0000, 8'h00, 16'h0000, 8'h01, DST_IY);
        run_op("hl_de", 1'b0, 1'b0, 2'd1, 16'h1234, 16'h1111, 8'h00, 16'h2345, 8'h00, DST_HL);
        run_op("hl_self", 1'b0, 1'b0, 2'd2, 16'hFFFF, 16'h0000, 8'h00, 16'hFFFE, 8'h11, DST_HL);
`endif
        run_op("hl_sp", 1'b0, 1'b0, 2'd3, 16'h0800, 16'h0800, 8'hC4, 16'h1000, 8'hD4, DST_HL);

        // Back-to-back: start held high through DONE.
        start = 1'b1;
        k = 0;
        while (!done && k < 20) begin @(negedge clk); k++; end
        check("b2b first", 16'(done), 16'd1);
        k = 0;
        @(negedge clk);
        k++;
        check("b2b relaunch busy", 16'(busy), 16'd1);
        check("b2b relaunch ts", 16'(tstate), 16'd1);
        start = 1'b0;
        while (!done && k < 20) begin @(negedge clk); k++; end
        check("b2b gap", 16'(k), 16'd8);
        @(negedge clk);

        // Abort by reset in LO tstate 2.
        scramble();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort ts2", 16'(tstate), 16'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 16'(busy), 16'd0);
        check("abort tstate", 16'(tstate), 16'd0);
        check("abort result", result_out, 16'h0000);
        check("abort f", 16'(f_out), 16'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || wr_en) seen_done++;
        end
        check("abort no done", 16'(seen_done), 16'd0);

        // Randomized traffic with sparse resets.
        for (int i = 0; i < 600; i++) begin
            scramble();
            start = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
